// File: rtl/ep6_slavefifo_wr.sv
// rtl/ep6_slavefifo_wr.sv - EP6 downstream stage: buffers the combiner stream and writes it to the FX3 slave FIFO.
// Packets close at PKT_WORDS (FX3 auto-commit) or with PKTEND after an idle timeout.
module ep6_slavefifo_wr #(
  parameter int         FIFO_AW    = 9,
  parameter int         PKT_WORDS  = 256,
  parameter int         TIMEOUT    = 1000,
  parameter int         GAP_CYCLES = 4,
  parameter logic [1:0] EP_ADDR    = 2'b11
) (
  input  logic               clk_100,
  input  logic               rst,
  input  logic [31:0]        din,
  input  logic               din_en,
  input  logic               fx_full_n,
  output logic [31:0]        fx_data,
  output logic [1:0]         fx_addr,
  output logic               fx_slwr_n,
  output logic               fx_pktend_n,
  output logic [FIFO_AW:0]   level,
  output logic               ovf
);

  localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int ICW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [WCW-1:0]   WC_LAST = WCW'(PKT_WORDS - 1);
  localparam logic [ICW-1:0]   IC_LAST = ICW'(TIMEOUT - 1);
  localparam logic [GCW-1:0]   GC_LAST = GCW'(GAP_CYCLES - 1);
  localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW + 1)'(1 << FIFO_AW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_PKTEND,
    S_GAP
  } state_t;

  state_t             state;
  logic [31:0]        mem [0:(1 << FIFO_AW) - 1];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic               full_r;
  logic [WCW-1:0]     word_cnt;
  logic [ICW-1:0]     idle_cnt;
  logic [GCW-1:0]     gap_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic wr_en;
  logic pop;

  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == DEPTH);
  assign wr_en      = din_en && !fifo_full;
  assign pop        = (state == S_WRITE) && !fifo_empty && full_r;
  assign fx_addr    = EP_ADDR;

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_100) begin
    if (wr_en) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      full_r      <= 1'b0;
      ovf         <= 1'b0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      gap_cnt     <= '0;
      fx_data     <= '0;
      fx_slwr_n   <= 1'b1;
      fx_pktend_n <= 1'b1;
    end else begin
      full_r      <= fx_full_n;
      fx_slwr_n   <= 1'b1;
      fx_pktend_n <= 1'b1;

      if (wr_en) begin
        wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
      end
      if (din_en && fifo_full) begin
        ovf <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
      end

      // Idle timer only runs for an open, partially filled packet with nothing pending.
      if (din_en || word_cnt == '0) begin
        idle_cnt <= '0;
      end else if (fifo_empty && idle_cnt != IC_LAST) begin
        idle_cnt <= idle_cnt + ICW'(1);
      end

      case (state)
        S_IDLE: begin
          if (!fifo_empty && full_r) begin
            state <= S_WRITE;
          end else if (word_cnt != '0 && !din_en && idle_cnt == IC_LAST) begin
            state       <= S_PKTEND;
            fx_pktend_n <= 1'b0;
          end
        end
        S_WRITE: begin
          if (pop) begin
            fx_data   <= mem[rd_ptr[FIFO_AW-1:0]];
            fx_slwr_n <= 1'b0;
            if (word_cnt == WC_LAST) begin
              word_cnt <= '0;
              gap_cnt  <= '0;
              state    <= S_GAP;
            end else begin
              word_cnt <= word_cnt + WCW'(1);
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_PKTEND: begin
          word_cnt <= '0;
          gap_cnt  <= '0;
          state    <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GC_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ep6_slavefifo_wr.sv
// tb/tb_ep6_slavefifo_wr.sv - directed scoreboard bench for ep6_slavefifo_wr.
module tb_ep6_slavefifo_wr;

  localparam int TIMEOUT    = 1000;
  localparam int GAP_CYCLES = 4;

  logic        clk_100 = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_en;
  logic        fx_full_n;
  logic [31:0] fx_data;
  logic [1:0]  fx_addr;
  logic        fx_slwr_n;
  logic        fx_pktend_n;
  logic [9:0]  level;
  logic        ovf;

  ep6_slavefifo_wr #(
    .FIFO_AW(9), .PKT_WORDS(256), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .EP_ADDR(2'b11)
  ) dut (
    .clk_100(clk_100), .rst(rst), .din(din), .din_en(din_en), .fx_full_n(fx_full_n),
    .fx_data(fx_data), .fx_addr(fx_addr), .fx_slwr_n(fx_slwr_n), .fx_pktend_n(fx_pktend_n),
    .level(level), .ovf(ovf)
  );

  always #5 clk_100 = ~clk_100;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int slwr_cnt = 0;
  int pktend_cnt = 0;
  int pktend_cyc = 0;
  int wr_cyc [4096];
  logic [31:0] sb [$];
  logic [31:0] exp_word;

  always @(posedge clk_100) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must carry the oldest outstanding word.
  always @(negedge clk_100) begin
    if (!rst) begin
      if (!fx_slwr_n) begin
        wr_cyc[slwr_cnt % 4096] = cyc;
        slwr_cnt++;
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL sb_underflow: observed write %0h expected none", fx_data);
        end
        if (sb.size() != 0) begin
          exp_word = sb.pop_front();
          check("fx_data", fx_data, exp_word);
        end
        check("no_dual_strobe", fx_pktend_n, 1);
      end
      if (!fx_pktend_n) begin
        pktend_cyc = cyc;
        pktend_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] d);
    din    = d;
    din_en = 1'b1;
    sb.push_back(d);
    tick();
  endtask

  task automatic wait_slwr(input string tag, input int target, input int bound);
    for (int k = 0; k < bound && slwr_cnt < target; k++) tick();
    check(tag, slwr_cnt >= target, 1);
  endtask

  task automatic wait_pktend(input string tag, input int target, input int bound);
    for (int k = 0; k < bound && pktend_cnt < target; k++) tick();
    check(tag, pktend_cnt >= target, 1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_slwr_n"},   fx_slwr_n,   1);
    check({pfx, "_pktend_n"}, fx_pktend_n, 1);
    check({pfx, "_data"},     fx_data,     0);
    check({pfx, "_addr"},     fx_addr,     2'b11);
    check({pfx, "_level"},    level,       0);
    check({pfx, "_ovf"},      ovf,         0);
  endtask

  int n0, c0, p0, c1, s0, stall_cnt, scyc;
  bit stalled, released;

  initial begin
    rst = 1'b1; din = '0; din_en = 1'b0; fx_full_n = 1'b1;
    ticks(3);
    check_reset("reset");
    rst = 1'b0;
    ticks(3);

    // Single burst: latency N+3 and PKTEND exactly TIMEOUT cycles after the write.
    c0 = slwr_cnt; p0 = pktend_cnt; n0 = cyc;
    push(32'hA5A5_0001);
    din_en = 1'b0;
    wait_slwr("burst_write_seen", c0 + 1, 20);
    check("burst_latency", wr_cyc[c0 % 4096], n0 + 3);
    wait_pktend("burst_pktend_seen", p0 + 1, TIMEOUT + 50);
    check("burst_pktend_time", pktend_cyc, wr_cyc[c0 % 4096] + TIMEOUT);
    check("burst_pktend_count", pktend_cnt, p0 + 1);
    ticks(10);

    // Full packet of 256 words plus one trailing word to measure the boundary gap.
    c0 = slwr_cnt; p0 = pktend_cnt;
    for (int i = 0; i < 256; i++) push(32'(i));
    push(32'h1234_5678);
    din_en = 1'b0;
    wait_slwr("pkt_writes_seen", c0 + 257, 700);
    check("pkt_contiguous", wr_cyc[(c0 + 255) % 4096] - wr_cyc[c0 % 4096], 255);
    check("pkt_gap", wr_cyc[(c0 + 256) % 4096] - wr_cyc[(c0 + 255) % 4096], GAP_CYCLES + 2);
    check("pkt_no_pktend", pktend_cnt, p0);
    wait_pktend("pkt_tail_pktend_seen", p0 + 1, TIMEOUT + 50);
    check("pkt_tail_pktend_time", pktend_cyc, wr_cyc[(c0 + 256) % 4096] + TIMEOUT);
    ticks(10);

    // Backpressure: stop FX3 after ~100 writes, hold 20 cycles, then release.
    c0 = slwr_cnt; p0 = pktend_cnt; stalled = 0; released = 0; scyc = 0;
    for (int i = 0; i < 200; i++) begin
      push(32'hB000_0000 + 32'(i));
      if (!stalled && slwr_cnt >= c0 + 100) begin
        fx_full_n = 1'b0;
        stall_cnt = slwr_cnt;
        stalled   = 1;
      end else if (stalled && !released) begin
        scyc++;
        if (scyc == 20) begin
          check("bp_extra_writes_le2", (slwr_cnt - stall_cnt) <= 2, 1);
          fx_full_n = 1'b1;
          released  = 1;
        end
      end
    end
    din_en = 1'b0;
    check("bp_stall_happened", released, 1);
    wait_slwr("bp_drain", c0 + 200, 400);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_no_early_pktend", pktend_cnt, p0);
    wait_pktend("bp_pktend_seen", p0 + 1, TIMEOUT + 100);
    ticks(10);

    // Overflow: FX3 held full, 513 words pushed into a 512-deep FIFO.
    fx_full_n = 1'b0;
    ticks(3);
    c0 = slwr_cnt; p0 = pktend_cnt;
    for (int i = 0; i < 513; i++) begin
      din    = 32'hC000_0000 + 32'(i);
      din_en = 1'b1;
      if (i < 512) sb.push_back(din);
      tick();
    end
    din_en = 1'b0;
    tick();
    check("ovf_level", level, 512);
    check("ovf_flag", ovf, 1);
    check("ovf_no_writes", slwr_cnt, c0);
    fx_full_n = 1'b1;
    wait_slwr("ovf_drain", c0 + 512, 1500);
    ticks(5);
    check("ovf_sticky", ovf, 1);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_level_empty", level, 0);
    check("ovf_no_pktend", pktend_cnt, p0);
    rst = 1'b1;
    tick();
    check_reset("ovf_rst");
    rst = 1'b0;
    ticks(10);

    // Timeout race: a word arrives exactly on the terminal-count cycle.
    c0 = slwr_cnt; p0 = pktend_cnt;
    push(32'hD000_0001);
    din_en = 1'b0;
    wait_slwr("race_first_write", c0 + 1, 20);
    s0 = wr_cyc[c0 % 4096];
    for (int k = 0; k < 2 * TIMEOUT && cyc < s0 + TIMEOUT - 1; k++) tick();
    push(32'hD000_0002);
    din_en = 1'b0;
    wait_slwr("race_second_write", c0 + 2, 20);
    ticks(20);
    check("race_no_pktend", pktend_cnt, p0);
    wait_pktend("race_pktend_seen", p0 + 1, TIMEOUT + 50);
    check("race_pktend_time", pktend_cyc, wr_cyc[(c0 + 1) % 4096] + TIMEOUT);
    check("race_pktend_count", pktend_cnt, p0 + 1);
    ticks(10);

    // Mid-packet reset around word 50; nothing may follow it.
    c0 = slwr_cnt;
    for (int i = 0; i < 100; i++) begin
      push(32'hE000_0000 + 32'(i));
      if (slwr_cnt >= c0 + 50) break;
    end
    din_en = 1'b0;
    rst    = 1'b1;
    tick();
    check_reset("midpkt_rst");
    rst = 1'b0;
    sb.delete();
    p0 = pktend_cnt; c1 = slwr_cnt;
    ticks(TIMEOUT + 50);
    check("midpkt_no_pktend", pktend_cnt, p0);
    check("midpkt_no_writes", slwr_cnt, c1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
